// File: rtl/game_pkg.sv
// Shared timing constants and state type for per-frame game logic.
// Coordinates follow standard 720p timing; pixels outside the active window are blanking.
package game_pkg;

  localparam int H_TOTAL  = 1650;
  localparam int V_TOTAL  = 750;
  localparam int H_ACTIVE = 1280;
  localparam int V_ACTIVE = 720;
  localparam int HP_W     = 4;

  typedef enum logic [1:0] {
    ARMED,
    INVULN,
    DEAD
  } dmg_state_t;

endpackage

// File: rtl/damage_gen_frame_tick.sv
// Combinational frame-end and active-area decode from the pixel counters.
// Kept separate so other per-frame game logic can share the same decode.
module frame_tick
  import game_pkg::*;
(
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  output logic        fe_out,
  output logic        in_active_out
);

  assign fe_out        = (hcount_in == 11'(H_TOTAL - 1)) && (vcount_in == 10'(V_TOTAL - 1));
  assign in_active_out = (hcount_in < 11'(H_ACTIVE)) && (vcount_in < 10'(V_ACTIVE));

endmodule

// File: rtl/damage_gen.sv
// Sprite-overlap damage producer: latches hits within a frame and converts them at frame end
// into one damage pulse that lands on pixel (0,0), tracking hp, invulnerability and game over.
module damage_gen
  import game_pkg::*;
#(
  parameter int MAX_HP        = 12,
  parameter int INVULN_FRAMES = 30
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [10:0]     hcount_in,
  input  logic [9:0]      vcount_in,
  input  logic [11:0]     player_pixel_in,
  input  logic [11:0]     hazard_pixel_in,
  input  logic            ext_hit_in,
  output logic            damage_out,
  output logic [HP_W-1:0] hp_out,
  output logic            invuln_out,
  output logic            game_over_out
);

  localparam int CNT_W = (INVULN_FRAMES > 0) ? $clog2(INVULN_FRAMES + 1) : 1;

  logic fe;
  logic in_active;
  logic hit_now;
  logic hit_frame;

  dmg_state_t      state_q, state_d;
  logic [HP_W-1:0] hp_q, hp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            latch_q, latch_d;
  logic            damage_q, damage_d;
  logic            invuln_q, invuln_d;
  logic            game_over_q, game_over_d;

  frame_tick u_frame_tick (
    .hcount_in     (hcount_in),
    .vcount_in     (vcount_in),
    .fe_out        (fe),
    .in_active_out (in_active)
  );

  assign hit_now   = ((player_pixel_in != 12'd0) && (hazard_pixel_in != 12'd0) && in_active)
                     || ext_hit_in;
  // A hit on the frame-end cycle itself still belongs to the frame being closed.
  assign hit_frame = latch_q || hit_now;

  always_comb begin
    state_d  = state_q;
    hp_d     = hp_q;
    cnt_d    = cnt_q;
    latch_d  = hit_frame;
    damage_d = 1'b0;
    if (fe) begin
      latch_d = 1'b0;
      case (state_q)
        ARMED: begin
          if (hit_frame) begin
            hp_d     = (hp_q == '0) ? '0 : hp_q - HP_W'(1);
            damage_d = 1'b1;
            if (hp_d == '0) begin
              state_d = DEAD;
            end else if (INVULN_FRAMES > 0) begin
              state_d = INVULN;
              cnt_d   = CNT_W'(INVULN_FRAMES);
            end
          end
        end
        INVULN: begin
          if (cnt_q == CNT_W'(1)) begin
            state_d = ARMED;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        DEAD:    state_d = DEAD;
        default: state_d = ARMED;
      endcase
    end
    invuln_d    = (state_d == INVULN);
    game_over_d = (state_d == DEAD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARMED;
      hp_q        <= HP_W'(MAX_HP);
      cnt_q       <= '0;
      latch_q     <= 1'b0;
      damage_q    <= 1'b0;
      invuln_q    <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hp_q        <= hp_d;
      cnt_q       <= cnt_d;
      latch_q     <= latch_d;
      damage_q    <= damage_d;
      invuln_q    <= invuln_d;
      game_over_q <= game_over_d;
    end
  end

  assign damage_out    = damage_q;
  assign hp_out        = hp_q;
  assign invuln_out    = invuln_q;
  assign game_over_out = game_over_q;

endmodule

// File: doc/damage_gen.md
Name: damage_gen

Overview:
- Producer side of the damage interface consumed by the on-screen health bar.
- Scans the pixel stream for overlap between the player sprite and hazard sprites, and latches hits within a frame.
- At each frame boundary, converts a latched hit into one damage pulse, aligned so the sink samples it at hcount=0, vcount=0.
- Tracks hit points, enforces invulnerability frames after each hit, and flags game over.

Parameters:
- H_TOTAL, 1650, total pixels per line (720p timing).
- V_TOTAL, 750, total lines per frame.
- H_ACTIVE, 1280, visible pixels per line.
- V_ACTIVE, 720, visible lines.
- MAX_HP, 12, hits to game over (matches 48-px bar at 4 px/hit).
- INVULN_FRAMES, 30, frames ignored after a hit (0 = none).

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- hcount_in  in  11  current pixel x
- vcount_in  in  10  current pixel y
- player_pixel_in  in  12  player sprite colour, same cycle as counts; 0 = transparent
- hazard_pixel_in  in  12  hazard sprite colour, same cycle as counts; 0 = transparent
- ext_hit_in  in  1  single-cycle hit request from other game logic
- damage_out  out  1  damage pulse to health bar
- hp_out  out  4  remaining hit points
- invuln_out  out  1  high while invulnerable (for sprite blink)
- game_over_out  out  1  high once hp reaches 0

Behaviour:
- Reset: damage_out=0, hp_out=MAX_HP, invuln_out=0, game_over_out=0, hit latch=0, state=ARMED, invuln counter=0.
- Overlap: a cycle counts as a hit only if both pixels are non-zero and hcount_in<H_ACTIVE and vcount_in<V_ACTIVE. It sets the hit latch. ext_hit_in=1 on any cycle also sets the latch.
- Frame end (fe) is the cycle with hcount_in=H_TOTAL-1 and vcount_in=V_TOTAL-1. All state updates occur on fe; the latch clears on fe.
- A hit or ext_hit_in arriving on the fe cycle itself counts for that frame.
- State ARMED, on fe:
  - Latch set: hp decrements by 1 and damage_out=1 on the next cycle (coincident with hcount=0, vcount=0).
  - If new hp=0, go to DEAD.
  - Else if INVULN_FRAMES>0, go to INVULN with cnt=INVULN_FRAMES.
  - Else stay in ARMED.
- State INVULN, on fe: the latch is discarded.
  - cnt=1: go to ARMED.
  - Otherwise: cnt decrements by 1.
  - invuln_out=1 throughout INVULN.
- State DEAD: game_over_out=1, no further pulses, hp_out holds 0. Leaves only on rst.
- damage_out is high for exactly one cycle and low on the cycle before. This guarantees a rising edge at (0,0) for a sink that registers the previous value and samples at (0,0).
- hp arithmetic: 4-bit unsigned, never decremented below 0.
- Reset mid-pulse or mid-invulnerability: all outputs return to reset values on the next edge.
- Counts outside range (hcount_in≥H_TOTAL): no fe, overlap ignored; no recovery logic required.

Decomposition:
- Package game_pkg holds:
  - H_TOTAL, V_TOTAL, H_ACTIVE, V_ACTIVE constants;
  - typedef enum logic[1:0] {ARMED, INVULN, DEAD} dmg_state_t;
  - HP_W=4.
- Sub-module frame_tick: combinational fe and in_active decode from hcount/vcount. It is reused by other per-frame game logic.

Test Plan:
- Overlap at (100,100) in frame 0, INVULN_FRAMES=30 → damage_out=1 only at (0,0) of frame 1; hp_out=11; invuln_out=1.
- Overlap every frame for 31 frames after first hit → no pulses; first new pulse at start of frame 32; hp_out=10.
- Overlap at (1300,100) (blanking), or only one pixel non-zero in active area → no pulse, hp_out unchanged.
- INVULN_FRAMES=0, overlap in 12 consecutive frames → 12 one-cycle pulses; hp_out=0; game_over_out=1; 13th overlap gives no pulse.
- ext_hit_in on the fe cycle while ARMED → pulse at the immediately following (0,0).
- rst asserted during the damage_out high cycle → damage_out=0, hp_out=12, invuln_out=0 next cycle.
